// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch and load/store,
//   serialising accesses through an IDLE/ISSUE/WAIT/RESP sequencer.
//   Optional macro: ARB_STARVE_GUARD_EN (bounded data priority over fetch).
//   Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic   owner_d;    // 1: current access belongs to load/store
  logic   lat_we;
  logic   any_req;
  logic   pick_data;
  logic   accept;
  logic   resp_take;

  assign any_req   = if_req | d_req;
  assign accept    = (state == ST_IDLE) & any_req;
  assign resp_take = (state == ST_WAIT) & mem_ack;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
  assign pick_data  = d_req & ~(if_req & starve_hit);

  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (pick_data && if_req) begin
        if (!starve_hit) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign pick_data = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        if_gnt    = ~owner_d;
        d_gnt     = owner_d;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if_rvalid = ~owner_d;
        d_rvalid  = owner_d;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request fields are captured once in IDLE so the memory side stays stable
  // even if the requester changes its inputs mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d   <= 1'b0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (accept) begin
        owner_d  <= pick_data;
        lat_we   <= pick_data & d_we;
        mem_addr <= pick_data ? d_addr : if_addr;
        if (pick_data) begin
          mem_wdata <= d_wdata;
        end
      end
      if (resp_take) begin
        if (owner_d) begin
          d_rdata <= lat_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire
